// File: rtl/trng_uart_rx.sv
// 8N1 UART receiver for the TRNG serial link, with a one-entry valid/ready holding register.
// Optional even-parity bit between data and stop when RX_PARITY_EN is defined.
module trng_uart_rx #(
  parameter  int CLKS_PER_BIT = 87,
  localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       RX_Serial,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_busy,
  output logic       o_frame_err,
  output logic       o_overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
`ifdef RX_PARITY_EN
    , S_PARITY
`endif
  } state_e;

  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q, hist_q;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d, data_q, data_d;
  logic             valid_q, valid_d, busy_q, ferr_q, ferr_d, ovr_q, ovr_d;
`ifdef RX_PARITY_EN
  logic             perr_q, perr_d;
`endif

  logic rx_s, rx_p;
  assign rx_s = sync2_q;
  assign rx_p = hist_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q & ~i_ready;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
`ifdef RX_PARITY_EN
    perr_d  = perr_q;
`endif
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (rx_p && !rx_s) state_d = S_START;
      end
      S_START: begin
        if (timer_q == HALF) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else timer_d = timer_q + 1'b1;
      end
      S_DATA: begin
        if (timer_q == FULL) begin
          timer_d        = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == 3'd7) begin
`ifdef RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else idx_d = idx_q + 3'd1;
        end else timer_d = timer_q + 1'b1;
      end
`ifdef RX_PARITY_EN
      S_PARITY: begin
        if (timer_q == FULL) begin
          timer_d = '0;
          perr_d  = rx_s ^ (^shift_q);
          state_d = S_STOP;
        end else timer_d = timer_q + 1'b1;
      end
`endif
      S_STOP: begin
        if (timer_q == FULL) begin
          timer_d = '0;
          state_d = S_IDLE;
`ifdef RX_PARITY_EN
          if (perr_q) ferr_d = 1'b1;
          else
`endif
          if (!rx_s) ferr_d = 1'b1;
          else if (valid_q && !i_ready) ovr_d = 1'b1;
          else begin
            // a load on the same edge as an accept keeps the register full
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end else timer_d = timer_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= S_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync1_q <= RX_Serial;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= (state_d != S_IDLE);
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_busy      = busy_q;
  assign o_frame_err = ferr_q;
  assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_trng_uart_rx.sv
// Directed bench for trng_uart_rx: expected bytes queued at send time, popped by a monitor on transfer.
module tb_trng_uart_rx;
  localparam int C = 8;

  logic       clk = 1'b0, rst = 1'b1, rx = 1'b1, i_ready = 1'b1;
  logic [7:0] o_data;
  logic       o_valid, o_busy, o_frame_err, o_overrun;

  trng_uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk_sys(clk), .rst(rst), .RX_Serial(rx), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_busy(o_busy), .o_frame_err(o_frame_err), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int obs_ferr = 0, obs_ovr = 0, exp_ferr = 0, exp_ovr = 0;
  int t_valid = -1, vcount = 0;
  logic prev_valid = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // monitor: checks every transferred byte against the scoreboard, counts flag pulses
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_byte: got %0h, expected none", o_data);
        end else chk("byte", {24'h0, o_data}, {24'h0, exp_q.pop_front()});
      end
      if (o_valid && !prev_valid && t_valid < 0) t_valid = cyc;
      if (o_valid) vcount++;
      if (o_frame_err) obs_ferr++;
      if (o_overrun) obs_ovr++;
    end
    prev_valid = o_valid;
  end

  task automatic bit_out(input logic b);
    rx = b;
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input logic par);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef RX_PARITY_EN
    bit_out(par);
`endif
    bit_out(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int t_fall, bcnt;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", {31'h0, o_valid}, 0);
    chk("rst_busy", {31'h0, o_busy}, 0);
    chk("rst_data", {24'h0, o_data}, 0);
    chk("rst_flags", {30'h0, o_frame_err, o_overrun}, 0);
    idle(4);

    // plain byte, latency and single-cycle valid
    exp_q.push_back(8'hA5);
    t_fall = cyc;
    send(8'hA5, 1'b1, ^8'hA5);
    idle(10);
    chk("latency", t_valid - t_fall, 79);
    chk("valid_cycles", vcount, 1);
    chk("ferr_a5", obs_ferr, exp_ferr);

    // short low glitch aborts at mid-bit
    bcnt = 0;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx = 1'b1;
    repeat (16) begin
      @(negedge clk);
      if (o_busy) bcnt++;
    end
    #1;
    chk("glitch_busy", bcnt, 4);
    chk("glitch_ferr", obs_ferr, exp_ferr);
    chk("glitch_ovr", obs_ovr, exp_ovr);

    // bad stop bit, line stuck low, then a normal byte
    send(8'h5A, 1'b0, ^8'h5A);
    exp_ferr++;
    rx = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("stuck_busy", {31'h0, o_busy}, 0);
    idle(2 * C);
    exp_q.push_back(8'h11);
    send(8'h11, 1'b1, ^8'h11);
    idle(10);
    chk("frame_err", obs_ferr, exp_ferr);

    // overrun with consumer stalled
    i_ready = 1'b0;
    exp_q.push_back(8'h3C);
    send(8'h3C, 1'b1, ^8'h3C);
    send(8'hC3, 1'b1, ^8'hC3);
    exp_ovr++;
    idle(4);
    @(negedge clk);
    chk("hold_valid", {31'h0, o_valid}, 1);
    chk("hold_data", {24'h0, o_data}, 8'h3C);
    chk("overrun", obs_ovr, exp_ovr);
    @(posedge clk);
    #1 i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("drain_valid", {31'h0, o_valid}, 0);
    idle(4);

    // reset during data bit 4 of 0xFF
    fork
      send(8'hFF, 1'b1, 1'b1);
      begin
        repeat (2 + C/2 + 4*C + 4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("mrst_valid", {31'h0, o_valid}, 0);
        chk("mrst_busy", {31'h0, o_busy}, 0);
        chk("mrst_data", {24'h0, o_data}, 0);
        chk("mrst_flags", {30'h0, o_frame_err, o_overrun}, 0);
      end
    join
    idle(10);
    exp_q.push_back(8'h81);
    send(8'h81, 1'b1, ^8'h81);
    idle(10);

`ifdef RX_PARITY_EN
    exp_q.push_back(8'h07);
    send(8'h07, 1'b1, 1'b1);
    idle(10);
    send(8'h07, 1'b1, 1'b0);
    exp_ferr++;
    idle(10);
`endif

    idle(20);
    chk("final_ferr", obs_ferr, exp_ferr);
    chk("final_ovr", obs_ovr, exp_ovr);
    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end
endmodule
